// File: rtl/mul_share_rr_sched.sv
// mul_share_rr_sched: round-robin time-sharing of one signed multiplier among NUM_REQ
// requesters, with a MUL_STAGES-deep stallable pipeline and an ID-tagged result port.
module mul_share_rr_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int A_W        = 14,
    parameter int B_W        = 9,
    parameter int P_W        = 21,
    parameter int MUL_STAGES = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
);
    localparam int L = MUL_STAGES - 1;

    logic [ID_W-1:0]       ptr;
    logic [NUM_REQ-1:0]    win;
    logic [ID_W-1:0]       win_id;
    logic                  found;
    logic                  advance;
    logic                  xfer;
    logic                  v0;
    logic [ID_W-1:0]       id0;
    logic signed [A_W-1:0] a0;
    logic signed [B_W-1:0] b0;
    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;
    logic signed [P_W-1:0] prod;
    logic                  p_v  [L];
    logic [ID_W-1:0]       p_id [L];
    logic [P_W-1:0]        p_p  [L];

    assign rsp_valid = p_v[L-1];
    assign rsp_id    = p_id[L-1];
    assign rsp_p     = p_p[L-1];
    assign advance   = !rsp_valid || rsp_ready;
    assign req_ready = win & {NUM_REQ{advance & ap_rst_n}};
    assign xfer      = found && advance;

    // Operands are widened to the result width first so the product wraps at P_W bits.
    assign ax   = P_W'(a0);
    assign bx   = P_W'(b0);
    assign prod = ax * bx;

    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                win_id = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        busy = v0;
        for (int i = 0; i < L; i++) busy = busy | p_v[i];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
            v0  <= 1'b0;
            id0 <= '0;
            a0  <= '0;
            b0  <= '0;
            for (int i = 0; i < L; i++) begin
                p_v[i]  <= 1'b0;
                p_id[i] <= '0;
                p_p[i]  <= '0;
            end
        end else if (advance) begin
            v0      <= xfer;
            id0     <= win_id;
            a0      <= req_a[int'(win_id)*A_W +: A_W];
            b0      <= req_b[int'(win_id)*B_W +: B_W];
            p_v[0]  <= v0;
            p_id[0] <= id0;
            p_p[0]  <= prod;
            for (int i = 1; i < L; i++) begin
                p_v[i]  <= p_v[i-1];
                p_id[i] <= p_id[i-1];
                p_p[i]  <= p_p[i-1];
            end
            if (xfer) ptr <= win_id;
        end
    end
endmodule

// File: tb/tb_mul_share_rr_sched.sv
// tb_mul_share_rr_sched: directed and random checks of mul_share_rr_sched against a
// queue-based model of in-flight requests.
module tb_mul_share_rr_sched;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int AW  = 14;
    localparam int BW  = 9;
    localparam int PW  = 21;
    localparam int MS  = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a = '0;
    logic [N*BW-1:0]   req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [PW-1:0]     rsp_p;
    logic              busy;

    mul_share_rr_sched #(.NUM_REQ(N), .ID_W(IW), .A_W(AW), .B_W(BW), .P_W(PW), .MUL_STAGES(MS)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int          id;
        logic [PW-1:0] p;
        int          pos;
    } ent_t;

    ent_t q[$];
    int   ptr = N - 1;
    int   last_g;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs driven; ends just after the next falling edge.
    task automatic cycle();
        logic          ev;
        logic          adv;
        int            g;
        logic [N-1:0]  er;
        int            pa;
        int            pb;
        logic [31:0]   t;
        ent_t          e;
        #1;
        ev  = q.size() > 0 && q[0].pos == MS;
        adv = !ev || rsp_ready;
        g   = -1;
        if (adv)
            for (int k = 1; k <= N; k++)
                if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (ev) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_p", 32'(rsp_p), 32'(q[0].p));
        end
        last_g = g;
        @(posedge ap_clk);
        if (adv) begin
            if (ev) void'(q.pop_front());
            foreach (q[i]) q[i].pos = q[i].pos + 1;
            if (g >= 0) begin
                pa    = $signed(req_a[g*AW +: AW]);
                pb    = $signed(req_b[g*BW +: BW]);
                t     = pa * pb;
                e.id  = g;
                e.p   = t[PW-1:0];
                e.pos = 1;
                q.push_back(e);
                ptr = g;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic single(input int j, input int a, input int b, input int want);
        logic [31:0] w;
        w = want;
        req_valid = '0;
        req_valid[j] = 1'b1;
        req_a[j*AW +: AW] = AW'(a);
        req_b[j*BW +: BW] = BW'(b);
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        #1;
        chk("lit_valid", 32'(rsp_valid), 32'd1);
        chk("lit_id", 32'(rsp_id), 32'(j));
        chk("lit_p", 32'(rsp_p), 32'(w[PW-1:0]));
        cycle();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'($urandom);
            req_b[i*BW +: BW] = BW'($urandom);
        end
    endtask

    initial begin
        int since;
        logic ok;
        #2;
        req_valid = 4'b1111;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_p", 32'(rsp_p), 32'd0);
        req_valid = '0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Single request: ready and in-flight busy are covered by the model; literal result here.
        single(2, 100, -3, -300);
        single(1, -8192, -256, 0);
        single(3, 8191, 255, -8447);

        // All requesters continuously valid: grants rotate, results back-to-back.
        rand_ops();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // Backpressure with requests pending.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        req_valid = '0;
        for (int i = 0; i < 4; i++) cycle();

        // Reset mid-flight with two entries in the pipeline.
        req_valid = 4'b0011;
        rand_ops();
        cycle();
        cycle();
        req_valid = '0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        q.delete();
        ptr = N - 1;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        req_valid = 4'b1001;
        cycle();
        chk("post_rst_first", 32'(last_g), 32'd0);
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle();

        // Starvation: requester 0 always valid, requester 3 raised at a random cycle.
        for (int r = 0; r < 5; r++) begin
            req_valid = 4'b0001;
            rsp_ready = 1'b1;
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                req_valid[2:1] = 2'($urandom);
                cycle();
            end
            req_valid[3] = 1'b1;
            since = 0;
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                req_valid[2:1] = 2'($urandom);
                rsp_ready = ($urandom_range(0, 3) != 0);
                rand_ops();
                cycle();
                if (last_g >= 0) since++;
                if (last_g == 3) ok = 1'b1;
            end
            chk("starve", 32'(ok && since <= N), 32'd1);
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            rand_ops();
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("drain_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
